lsc_led_con_mc: RTL and testbench
=================================

LSC_LED_CON_MC -- requirements
Module: lsc_led_con_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent LED channels (1..16).
REQ-002 Parameter CLK_FREQ, default 27000, clk cycles per 1 ms tick (clock frequency in kHz).
REQ-003 Parameter ON_TIME, default 300, flash on-duration in ms ticks.
REQ-004 Parameter OFF_TIME, default 500, post-flash hold-off in ms ticks.
REQ-005 Parameter CNT_W, default 16, width of each per-channel ms counter; ON_TIME and OFF_TIME SHALL be in 1..2^CNT_W-1, else elaboration error.
REQ-006 Parameter OFF_OVERRIDE, default 0; 1 = hold-off aborts when fire drops.
REQ-007 clk  in  1  single system clock, all logic on rising edge.
REQ-008 resetn  in  1  reset, synchronous, active-low.
REQ-009 i_enable  in  NUM_CH  per-channel enable.
REQ-010 i_fire  in  NUM_CH  per-channel trigger request, level-sensitive.
REQ-011 i_mode  in  2*NUM_CH  per-channel mode, channel n at [2n+1:2n]: 00 OFF, 01 ONESHOT, 10 BLINK, 11 SOLID.
REQ-012 o_on  out  NUM_CH  LED drive, 1 = lit.
REQ-013 o_busy  out  NUM_CH  1 while channel FSM is not IDLE.

Function
REQ-014 One shared prescaler SHALL count 0..CLK_FREQ-1 free-running and assert a one-cycle tick when at CLK_FREQ-1.
REQ-015 Each channel SHALL register i_enable into en_q (one-cycle delay); en_q low forces state IDLE, cnt 0, r_on 0 on that edge, overriding all other conditions.
REQ-016 Per-channel FSM states: IDLE, ON, HOLD.
REQ-017 IDLE->ON when en_q=1, i_fire=1, mode in {ONESHOT, BLINK}; load cnt=ON_TIME, latch mode into mode_q, r_on<=1.
REQ-018 Mode is latched only on IDLE->ON; i_mode changes during ON/HOLD take effect at next trigger.
REQ-019 In ON/HOLD, cnt SHALL decrement by 1 on each tick while cnt!=0; no wrap below 0.
REQ-020 ON with cnt==0 -> HOLD, load cnt=OFF_TIME, r_on<=0.
REQ-021 HOLD with cnt==0: if mode_q=BLINK and i_fire=1 -> ON (reload ON_TIME, r_on<=1); otherwise -> IDLE.
REQ-022 HOLD with OFF_OVERRIDE=1 and i_fire=0 -> IDLE immediately, cnt<=0; this takes priority over REQ-021.
REQ-023 ON state SHALL NOT be cut short by i_fire dropping; fire asserted in ON/HOLD is otherwise ignored.
REQ-024 SOLID mode: channel stays IDLE, r_on<=i_fire each cycle while en_q=1; OFF mode: r_on<=0, no trigger.
REQ-025 Resulting lit duration per flash: (ON_TIME-1)*CLK_FREQ+2 .. ON_TIME*CLK_FREQ+1 cycles, depending on prescaler phase.
REQ-026 o_on[n] = r_on[n] & i_enable[n] (combinational kill, zero-latency disable); o_busy[n] registered from state!=IDLE.
REQ-027 Channels SHALL be fully independent; simultaneous triggers on all channels behave as each alone.

Reset
REQ-028 On resetn=0 at a clk edge: prescaler 0, all en_q 0, state IDLE, cnt 0, mode_q OFF, r_on 0; o_on=0, o_busy=0 from the following cycle.
REQ-029 Reset mid-flash SHALL abandon the flash; no resumption after release.

Structure
REQ-030 Package lsc_led_pkg SHALL hold the mode encodings and FSM state encodings.
REQ-031 One sub-module lsc_led_chan (en sync, FSM, counter) SHALL be instantiated NUM_CH times; prescaler lives in the top level.

Verification (NUM_CH=2, CLK_FREQ=4, ON_TIME=3, OFF_TIME=2, CNT_W=4)
REQ-032 ONESHOT ch0, enable high, fire pulsed 1 cycle -> o_on[0] high 10..13 cycles, then low, o_busy[0] low after further 6..9 cycles; ch1 stays 0.
REQ-033 BLINK ch1, fire held 60 cycles -> repeated on/off cycles; releasing fire during HOLD -> no further ON, o_busy returns 0.
REQ-034 OFF_OVERRIDE=1, ONESHOT, fire dropped during HOLD -> IDLE next edge, o_busy 0 two cycles later max; new fire retriggers immediately.
REQ-035 i_enable[0] dropped mid-ON -> o_on[0]=0 same cycle, state IDLE one edge later; re-enable with fire low -> o_on stays 0.
REQ-036 SOLID ch0: fire toggled -> o_on[0] follows with 1-cycle latency; i_mode changed ONESHOT->OFF during ON -> flash completes unchanged.
REQ-037 resetn low 1 cycle mid-HOLD on both channels -> all outputs 0, prescaler restarts at 0, no residual flash.

Source files
------------

// File: rtl/lsc_led_pkg.sv
// Shared encodings for the LED flash controller: channel modes and channel FSM states.
package lsc_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_SOLID   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ON   = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/lsc_led_chan.sv
// One LED channel: enable synchroniser, flash FSM and ms down-counter driven by the shared tick.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a trigger; SOLID/OFF modes are served from here
//   ST_ON   | LED lit, counting ON_TIME ticks down
//   ST_HOLD | LED dark, counting OFF_TIME ticks of post-flash hold-off
module lsc_led_chan
  import lsc_led_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int ON_TIME      = 300,
  parameter int OFF_TIME     = 500,
  parameter int OFF_OVERRIDE = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable_i,
  input  logic       fire_i,
  input  logic [1:0] mode_i,
  input  logic       tick_i,
  output logic       on_o,
  output logic       busy_o
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ron_q, ron_d;
  logic               en_q;
  logic               busy_q;
  mode_e              mode_in;

  assign mode_in = mode_e'(mode_i);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_q    <= 1'b0;
      state_q <= ST_IDLE;
      mode_q  <= MODE_OFF;
      cnt_q   <= '0;
      ron_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      en_q    <= enable_i;
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      ron_q   <= ron_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    ron_d   = ron_q;
    if (!en_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ron_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (mode_in)
            MODE_SOLID: ron_d = fire_i;
            MODE_OFF:   ron_d = 1'b0;
            default: begin
              ron_d = 1'b0;
              if (fire_i) begin
                state_d = ST_ON;
                cnt_d   = CNT_W'(ON_TIME);
                mode_d  = mode_in;
                ron_d   = 1'b1;
              end
            end
          endcase
        end
        ST_ON: begin
          if (cnt_q == '0) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(OFF_TIME);
            ron_d   = 1'b0;
          end else if (tick_i) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          // Override abort wins over the normal end-of-hold decision.
          if ((OFF_OVERRIDE != 0) && !fire_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            if ((mode_q == MODE_BLINK) && fire_i) begin
              state_d = ST_ON;
              cnt_d   = CNT_W'(ON_TIME);
              ron_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (tick_i) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ron_d   = 1'b0;
        end
      endcase
    end
  end

  assign on_o   = ron_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/lsc_led_con_mc.sv
// Multi-channel LED flash controller: shared 1 ms prescaler feeding NUM_CH independent channels.
module lsc_led_con_mc
  import lsc_led_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CLK_FREQ     = 27000,
  parameter int ON_TIME      = 300,
  parameter int OFF_TIME     = 500,
  parameter int CNT_W        = 16,
  parameter int OFF_OVERRIDE = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_CH-1:0]   i_enable,
  input  logic [NUM_CH-1:0]   i_fire,
  input  logic [2*NUM_CH-1:0] i_mode,
  output logic [NUM_CH-1:0]   o_on,
  output logic [NUM_CH-1:0]   o_busy
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("lsc_led_con_mc: NUM_CH out of range 1..16");
  end
  if (ON_TIME < 1 || ON_TIME > (2 ** CNT_W) - 1) begin : g_bad_on_time
    $error("lsc_led_con_mc: ON_TIME does not fit CNT_W");
  end
  if (OFF_TIME < 1 || OFF_TIME > (2 ** CNT_W) - 1) begin : g_bad_off_time
    $error("lsc_led_con_mc: OFF_TIME does not fit CNT_W");
  end

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [NUM_CH-1:0] r_on;

  assign tick    = (presc_q == PW'(CLK_FREQ - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) presc_q <= '0;
    else         presc_q <= presc_d;
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    lsc_led_chan #(
      .CNT_W        (CNT_W),
      .ON_TIME      (ON_TIME),
      .OFF_TIME     (OFF_TIME),
      .OFF_OVERRIDE (OFF_OVERRIDE)
    ) u_chan (
      .clk      (clk),
      .resetn   (resetn),
      .enable_i (i_enable[n]),
      .fire_i   (i_fire[n]),
      .mode_i   (i_mode[2*n +: 2]),
      .tick_i   (tick),
      .on_o     (r_on[n]),
      .busy_o   (o_busy[n])
    );
  end

  // Raw enable gates the drive so a disable darkens the LED without waiting a clock.
  assign o_on = r_on & i_enable;

endmodule

// File: tb/tb_lsc_led_con_mc.sv
// Scoreboard bench for lsc_led_con_mc: two instances (hold-off override off/on), directed flash scenarios.
module tb_lsc_led_con_mc;

   logic       clk = 1'b0;
   logic       resetn;
   logic [1:0] en0, fire0, en1, fire1;
   logic [3:0] mode0, mode1;
   logic [1:0] on0, busy0, on1, busy1;
   int         meas;
   int         n_checks = 0;
   int         n_err = 0;

   typedef struct {
      string name;
      int    kind;
      int    lo;
      int    hi;
   } exp_t;

   exp_t sb_q[$];
   event mon_ev;

   always #5 clk = ~clk;

   lsc_led_con_mc #(
      .NUM_CH(2), .CLK_FREQ(4), .ON_TIME(3), .OFF_TIME(2), .CNT_W(4), .OFF_OVERRIDE(0)
   ) dut0 (
      .clk(clk), .resetn(resetn), .i_enable(en0), .i_fire(fire0),
      .i_mode(mode0), .o_on(on0), .o_busy(busy0)
   );

   lsc_led_con_mc #(
      .NUM_CH(2), .CLK_FREQ(4), .ON_TIME(3), .OFF_TIME(2), .CNT_W(4), .OFF_OVERRIDE(1)
   ) dut1 (
      .clk(clk), .resetn(resetn), .i_enable(en1), .i_fire(fire1),
      .i_mode(mode1), .o_on(on1), .o_busy(busy1)
   );

   // kind: 0 dut0 o_on, 1 dut0 o_busy, 2 measured cycle count, 3 dut1 o_on, 4 dut1 o_busy
   initial begin
      forever begin
         @(mon_ev);
         while (sb_q.size() > 0) begin
            exp_t e;
            int   act;
            e = sb_q.pop_front();
            case (e.kind)
               0:       act = int'(on0);
               1:       act = int'(busy0);
               2:       act = meas;
               3:       act = int'(on1);
               default: act = int'(busy1);
            endcase
            n_checks++;
            if (act < e.lo || act > e.hi) begin
               n_err++;
               $display("FAIL %s: actual %0d, required %0d..%0d", e.name, act, e.lo, e.hi);
            end
         end
      end
   end

   task automatic check(input string name, input int kind, input int lo, input int hi);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.lo   = lo;
      e.hi   = hi;
      sb_q.push_back(e);
      ->mon_ev;
      wait (sb_q.size() == 0);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return on0[0];
         1:       return on0[1];
         2:       return busy0[0];
         3:       return busy0[1];
         4:       return on1[0];
         5:       return busy1[0];
         default: return 1'b0;
      endcase
   endfunction

   // Counts sampled cycles while the selected signal holds val; bound expiry leaves meas = bound.
   task automatic count_while(input int sel, input logic val, input int bound);
      meas = 0;
      while (sig(sel) == val && meas < bound) begin
         meas++;
         step(1);
      end
   endtask

   task automatic count_rises(input int sel, input int cycles);
      logic prev;
      int   rises;
      rises = 0;
      prev  = sig(sel);
      for (int i = 0; i < cycles; i++) begin
         step(1);
         if (sig(sel) && !prev) rises++;
         prev = sig(sel);
      end
      meas = rises;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      en0 = '0; fire0 = '0; mode0 = '0;
      en1 = '0; fire1 = '0; mode1 = '0;
      step(3);
      check("rst_on0", 0, 0, 0);
      check("rst_busy0", 1, 0, 0);
      check("rst_on1", 3, 0, 0);
      check("rst_busy1", 4, 0, 0);
      n_checks++;
      if (on0 !== 2'b00 || busy0 !== 2'b00) begin
         n_err++;
         $display("FAIL rst_direct0: on0=%b busy0=%b", on0, busy0);
      end
      n_checks++;
      if (on1 !== 2'b00 || busy1 !== 2'b00) begin
         n_err++;
         $display("FAIL rst_direct1: on1=%b busy1=%b", on1, busy1);
      end
      resetn = 1'b1;

      // ONESHOT ch0, single-cycle fire
      en0 = 2'b11; mode0 = 4'b0101;
      step(2);
      fire0 = 2'b01;
      step(1);
      fire0 = 2'b00;
      check("a_ch1_dark", 0, 1, 1);
      count_while(0, 1'b1, 40);
      check("a_lit_len", 2, 10, 13);
      count_while(2, 1'b1, 40);
      check("a_hold_len", 2, 6, 9);
      check("a_idle", 1, 0, 0);

      // BLINK ch1 with fire held, then released during HOLD
      mode0 = 4'b1001;
      fire0 = 2'b10;
      count_rises(1, 60);
      check("b_blink_flashes", 2, 3, 4);
      count_while(1, 1'b1, 40);
      check("b_wait_hold", 2, 0, 39);
      fire0 = 2'b00;
      count_rises(1, 40);
      check("b_no_reflash", 2, 0, 0);
      check("b_busy_clear", 1, 0, 0);

      // hold-off override instance, ONESHOT ch0
      en1 = 2'b01; mode1 = 4'b0001;
      step(2);
      fire1 = 2'b01;
      step(1);
      check("c_on", 3, 1, 1);
      count_while(4, 1'b1, 40);
      check("c_lit_len", 2, 10, 13);
      fire1 = 2'b00;
      count_while(5, 1'b1, 5);
      check("c_abort_busy", 2, 1, 2);
      fire1 = 2'b01;
      step(1);
      check("c_retrig", 3, 1, 1);
      fire1 = 2'b00;
      step(1);
      count_while(4, 1'b1, 40);
      check("c_retrig_len", 2, 9, 12);
      count_while(5, 1'b1, 5);
      check("c_abort_busy2", 2, 1, 2);

      // enable dropped mid-ON
      mode0 = 4'b0001;
      fire0 = 2'b01;
      step(1);
      fire0 = 2'b00;
      step(3);
      check("d_on_before", 0, 1, 1);
      en0 = 2'b10;
      #1;
      check("d_kill", 0, 0, 0);
      n_checks++;
      if (on0[0] !== 1'b0 || on0[1] !== 1'b0) begin
         n_err++;
         $display("FAIL d_kill_direct: on0=%b", on0);
      end
      count_while(2, 1'b1, 10);
      check("d_busy_drop", 2, 1, 2);
      en0 = 2'b11;
      step(5);
      check("d_reen_dark", 0, 0, 0);
      check("d_reen_idle", 1, 0, 0);

      // SOLID follows fire, then mode change during a flash
      mode0 = 4'b0011;
      fire0 = 2'b01;
      #1;
      check("e_solid_lat0", 0, 0, 0);
      step(1);
      check("e_solid_on", 0, 1, 1);
      fire0 = 2'b00;
      #1;
      check("e_solid_lat1", 0, 1, 1);
      step(1);
      check("e_solid_off", 0, 0, 0);
      mode0 = 4'b0001;
      step(1);
      fire0 = 2'b01;
      step(1);
      fire0 = 2'b00;
      mode0 = 4'b0000;
      count_while(0, 1'b1, 40);
      check("e_modechg_len", 2, 10, 13);
      count_while(2, 1'b1, 40);
      check("e_modechg_hold", 2, 6, 9);

      // both channels together, reset mid-HOLD, prescaler phase restart
      mode0 = 4'b0101;
      fire0 = 2'b11;
      step(1);
      fire0 = 2'b00;
      check("f_both_on", 0, 3, 3);
      count_while(0, 1'b1, 40);
      check("f_both_len", 2, 10, 13);
      check("f_both_off", 0, 0, 0);
      step(1);
      check("f_both_hold", 1, 3, 3);
      resetn = 1'b0;
      step(1);
      resetn = 1'b1;
      check("f_rst_on", 0, 0, 0);
      check("f_rst_busy", 1, 0, 0);
      step(2);
      check("f_no_residual", 0, 0, 0);
      fire0 = 2'b11;
      step(1);
      fire0 = 2'b00;
      count_while(0, 1'b1, 40);
      check("f_phase_len", 2, 10, 10);
      check("f_after_off", 0, 0, 0);
      count_while(2, 1'b1, 40);
      check("f_phase_hold", 2, 8, 8);
      step(30);
      check("f_quiet_on", 0, 0, 0);
      check("f_quiet_busy", 1, 0, 0);

      if (n_err != 0 || n_checks < 12)
         $display("FAIL summary: %0d checks, %0d errors", n_checks, n_err);
      else
         $display("PASS");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
